// File: rtl/vga_fb_pkg.sv
// Shared framebuffer geometry, sprite constants and sequencer state encoding
// for the VGA sprite drawing controller.
package vga_fb_pkg;

    localparam int H_RES     = 160;
    localparam int V_RES     = 120;
    localparam int AW        = 15;
    localparam int DW        = 3;
    localparam int SPR_W     = 16;
    localparam int SPR_H     = 8;
    localparam int SPR_Y     = 100;
    localparam int STEP      = 4;
    localparam int FB_PIXELS = H_RES * V_RES;

    localparam logic [DW-1:0] BG_COLOR  = 3'b000;
    localparam logic [DW-1:0] SPR_COLOR = 3'b111;

    localparam logic [7:0] X_MAX  = 8'(H_RES - SPR_W);
    localparam logic [7:0] X_HOME = 8'((H_RES - SPR_W) / 2);

    typedef enum logic [2:0] {
        CLEAR_ARM,
        CLEAR,
        IDLE,
        ERASE,
        DRAW
    } state_e;

    // Saturating one-step move; a result equal to x means the sprite is pinned at an edge.
    function automatic logic [7:0] next_x(input logic [7:0] x, input logic left);
        logic [8:0] sum;
        sum = {1'b0, x} + 9'(STEP);
        if (left) begin
            return (x >= 8'(STEP)) ? x - 8'(STEP) : 8'd0;
        end
        return (sum > {1'b0, X_MAX}) ? X_MAX : sum[7:0];
    endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer for an active-low pushbutton followed by a
// falling-edge detector that yields a single-cycle press pulse.
module btn_sync_edge (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_ni,
    output logic press_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    // Reset to the released level so a button held through reset never fires.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= btn_ni;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign press_o = prev_q & ~sync2_q;

endmodule

// File: rtl/vga_sprite_draw_ctrl.sv
// Owns the framebuffer write port: clears the frame, draws the sprite, and
// performs erase/redraw moves aligned to vertical blanking.
module vga_sprite_draw_ctrl
    import vga_fb_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          init,
    input  logic          bntl,
    input  logic          bntr,
    input  logic          vblank_start,
    output logic          fb_we,
    output logic [AW-1:0] fb_addr,
    output logic [DW-1:0] fb_data,
    output logic          busy,
    output logic [7:0]    sprite_x
);

    localparam int CW = $clog2(SPR_W);
    localparam int RW = $clog2(SPR_H);
    localparam logic [AW-1:0] ROW0 = AW'(SPR_Y * H_RES);

    state_e          state_q, state_d;
    logic [AW-1:0]   clr_cnt_q, clr_cnt_d;
    logic [CW-1:0]   col_q, col_d;
    logic [RW-1:0]   row_q, row_d;
    logic [AW-1:0]   row_base_q, row_base_d;
    logic [7:0]      sprite_x_q, sprite_x_d;
    logic [7:0]      new_x_q, new_x_d;
    logic            pend_l_q, pend_l_d;
    logic            pend_r_q, pend_r_d;
    logic            we_q, we_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   data_q, data_d;

    logic            init_press;
    logic            press_l;
    logic            press_r;
    logic [7:0]      cand_x;
    logic            col_last;
    logic            rect_last;

    btn_sync_edge u_sync_init (
        .clk_i   (clk),
        .rst_ni  (rst),
        .btn_ni  (init),
        .press_o (init_press)
    );

    btn_sync_edge u_sync_left (
        .clk_i   (clk),
        .rst_ni  (rst),
        .btn_ni  (bntl),
        .press_o (press_l)
    );

    btn_sync_edge u_sync_right (
        .clk_i   (clk),
        .rst_ni  (rst),
        .btn_ni  (bntr),
        .press_o (press_r)
    );

    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        col_d      = col_q;
        row_d      = row_q;
        row_base_d = row_base_q;
        sprite_x_d = sprite_x_q;
        new_x_d    = new_x_q;
        pend_l_d   = pend_l_q | press_l;
        pend_r_d   = pend_r_q | press_r;
        we_d       = 1'b0;
        addr_d     = addr_q;
        data_d     = data_q;
        cand_x     = next_x(sprite_x_q, pend_l_q);
        col_last   = (col_q == CW'(SPR_W - 1));
        rect_last  = col_last && (row_q == RW'(SPR_H - 1));

        case (state_q)
            CLEAR_ARM: begin
                clr_cnt_d = '0;
                state_d   = CLEAR;
            end
            CLEAR: begin
                we_d       = 1'b1;
                addr_d     = clr_cnt_q;
                data_d     = BG_COLOR;
                col_d      = '0;
                row_d      = '0;
                row_base_d = ROW0;
                if (clr_cnt_q == AW'(FB_PIXELS - 1)) begin
                    state_d = DRAW;
                end else begin
                    clr_cnt_d = clr_cnt_q + AW'(1);
                end
            end
            IDLE: begin
                // A press landing in the same cycle a flag is consumed stays pending.
                if (vblank_start && (pend_l_q || pend_r_q)) begin
                    if (pend_l_q && pend_r_q) begin
                        pend_l_d = press_l;
                        pend_r_d = press_r;
                    end else begin
                        if (pend_l_q) begin
                            pend_l_d = press_l;
                        end else begin
                            pend_r_d = press_r;
                        end
                        if (cand_x != sprite_x_q) begin
                            new_x_d = cand_x;
                            state_d = ERASE;
                        end
                    end
                end
            end
            ERASE, DRAW: begin
                we_d   = 1'b1;
                addr_d = row_base_q + AW'(sprite_x_q) + AW'(col_q);
                data_d = (state_q == ERASE) ? BG_COLOR : SPR_COLOR;
                if (col_last) begin
                    col_d      = '0;
                    row_d      = row_q + RW'(1);
                    row_base_d = row_base_q + AW'(H_RES);
                end else begin
                    col_d = col_q + CW'(1);
                end
                // sprite_x still holds the old column throughout ERASE.
                if (rect_last) begin
                    row_d      = '0;
                    row_base_d = ROW0;
                    if (state_q == ERASE) begin
                        sprite_x_d = new_x_q;
                        state_d    = DRAW;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = CLEAR_ARM;
            end
        endcase

        if (init_press) begin
            state_d    = CLEAR;
            clr_cnt_d  = '0;
            sprite_x_d = X_HOME;
            pend_l_d   = 1'b0;
            pend_r_d   = 1'b0;
            we_d       = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= CLEAR_ARM;
            clr_cnt_q  <= '0;
            col_q      <= '0;
            row_q      <= '0;
            row_base_q <= ROW0;
            sprite_x_q <= X_HOME;
            new_x_q    <= X_HOME;
            pend_l_q   <= 1'b0;
            pend_r_q   <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= BG_COLOR;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            col_q      <= col_d;
            row_q      <= row_d;
            row_base_q <= row_base_d;
            sprite_x_q <= sprite_x_d;
            new_x_q    <= new_x_d;
            pend_l_q   <= pend_l_d;
            pend_r_q   <= pend_r_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
        end
    end

    assign fb_we    = we_q;
    assign fb_addr  = addr_q;
    assign fb_data  = data_q;
    assign busy     = (state_q != IDLE);
    assign sprite_x = sprite_x_q;

endmodule

// File: tb/tb_vga_sprite_draw_ctrl.sv
// Self-checking bench for vga_sprite_draw_ctrl: every framebuffer write is
// logged and compared with a pixel-level model of clear, erase and draw.
`timescale 1ns/1ps
module tb_vga_sprite_draw_ctrl;

    localparam int W      = 160;
    localparam int PIX    = 19200;
    localparam int SY     = 100;
    localparam int SW     = 16;
    localparam int SH     = 8;
    localparam int XMAXM  = 144;
    localparam int HOME   = 72;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        init = 1'b1;
    logic        bntl = 1'b1;
    logic        bntr = 1'b1;
    logic        vblank_start = 1'b0;
    logic        fb_we;
    logic [14:0] fb_addr;
    logic [2:0]  fb_data;
    logic        busy;
    logic [7:0]  sprite_x;

    int errors = 0;
    int checks = 0;
    int cycle = 0;
    int busy_seen = 0;
    int model_x = HOME;

    logic [17:0] obs_q[$];
    int          stamp_q[$];
    logic [17:0] exp_q[$];

    int          bad_idx;
    logic [17:0] bad_got;
    logic [17:0] bad_exp;

    vga_sprite_draw_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .init         (init),
        .bntl         (bntl),
        .bntr         (bntr),
        .vblank_start (vblank_start),
        .fb_we        (fb_we),
        .fb_addr      (fb_addr),
        .fb_data      (fb_data),
        .busy         (busy),
        .sprite_x     (sprite_x)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    always @(negedge clk) begin
        if (fb_we === 1'b1) begin
            obs_q.push_back({fb_addr, fb_data});
            stamp_q.push_back(cycle);
        end
        if (busy === 1'b1) busy_seen++;
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "[TB] watchdog");
    end

    // ---------------- behavioural model ----------------
    function automatic void push_clear();
        for (int a = 0; a < PIX; a++) exp_q.push_back({15'(a), 3'b000});
    endfunction

    function automatic void push_rect(int x, logic [2:0] c);
        for (int r = 0; r < SH; r++)
            for (int cc = 0; cc < SW; cc++)
                exp_q.push_back({15'((SY + r) * W + x + cc), c});
    endfunction

    function automatic int moved(int x, bit left);
        int n;
        n = left ? x - 4 : x + 4;
        if (n < 0) n = 0;
        if (n > XMAXM) n = XMAXM;
        return n;
    endfunction

    function automatic int seq_mismatch(int start);
        int n;
        logic [17:0] got;
        n = 0;
        bad_idx = -1;
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (start + i < obs_q.size()) ? obs_q[start + i] : 18'bx;
            if (got !== exp_q[i]) begin
                if (n == 0) begin
                    bad_idx = i;
                    bad_got = got;
                    bad_exp = exp_q[i];
                end
                n++;
            end
        end
        return n;
    endfunction

    function automatic int gap_count(int start);
        int n;
        n = 0;
        for (int i = start + 1; i < stamp_q.size(); i++)
            if (stamp_q[i] != stamp_q[i-1] + 1) n++;
        return n;
    endfunction

    function automatic void clear_logs();
        obs_q.delete();
        stamp_q.delete();
        exp_q.delete();
        busy_seen = 0;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(int which);
        int hold;
        hold = $urandom_range(3, 6);
        if (which == 0) bntl = 1'b0;
        else if (which == 1) bntr = 1'b0;
        else init = 1'b0;
        tick(hold);
        bntl = 1'b1;
        bntr = 1'b1;
        init = 1'b1;
        tick(3);
    endtask

    task automatic pulse_vblank();
        @(posedge clk);
        #1 vblank_start = 1'b1;
        @(posedge clk);
        #1 vblank_start = 1'b0;
    endtask

    task automatic wait_idle(int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (3) @(negedge clk);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        bit ok;
        int n;
        rst = 1'b0;
        tick(3);
        @(negedge clk);
        checks++; if (fb_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_we: got %b want 0", fb_we); end
        checks++; if (fb_addr !== 15'd0) begin errors++; $display("[TB] FAIL reset_addr: got %0d want 0", fb_addr); end
        checks++; if (fb_data !== 3'b000) begin errors++; $display("[TB] FAIL reset_data: got %b want 000", fb_data); end
        checks++; if (sprite_x !== 8'(HOME)) begin errors++; $display("[TB] FAIL reset_sprite_x: got %0d want %0d", sprite_x, HOME); end
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL reset_busy: got %b want 1", busy); end
        tick(1);
        clear_logs();
        rst = 1'b1;
        wait_idle(25000, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL init_idle_timeout: busy never fell"); end
        push_clear();
        push_rect(HOME, 3'b111);
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL init_write_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        n = seq_mismatch(0);
        checks++; if (n != 0) begin errors++; $display("[TB] FAIL init_sequence: %0d bad, first at %0d got %h want %h", n, bad_idx, bad_got, bad_exp); end
        if (obs_q.size() > PIX + 127) begin
            checks++; if (obs_q[PIX][17:3] !== 15'd16072) begin errors++; $display("[TB] FAIL first_draw_addr: got %0d want 16072", obs_q[PIX][17:3]); end
            checks++; if (obs_q[PIX+127][17:3] !== 15'd17207) begin errors++; $display("[TB] FAIL last_draw_addr: got %0d want 17207", obs_q[PIX+127][17:3]); end
        end
        n = gap_count(0);
        checks++; if (n != 0) begin errors++; $display("[TB] FAIL init_gapless: got %0d gaps want 0", n); end
        checks++; if (sprite_x !== 8'(HOME)) begin errors++; $display("[TB] FAIL init_sprite_x: got %0d want %0d", sprite_x, HOME); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL init_busy: got %b want 0", busy); end
    endtask

    task automatic test_both_buttons();
        clear_logs();
        press(0);
        press(1);
        tick($urandom_range(1, 20));
        pulse_vblank();
        tick(6);
        checks++; if (obs_q.size() != 0) begin errors++; $display("[TB] FAIL both_writes: got %0d want 0", obs_q.size()); end
        checks++; if (busy_seen != 0) begin errors++; $display("[TB] FAIL both_busy: got %0d busy cycles want 0", busy_seen); end
        checks++; if (sprite_x !== 8'(model_x)) begin errors++; $display("[TB] FAIL both_sprite_x: got %0d want %0d", sprite_x, model_x); end
        pulse_vblank();
        tick(6);
        checks++; if (obs_q.size() != 0) begin errors++; $display("[TB] FAIL both_flags_cleared: got %0d writes want 0", obs_q.size()); end
    endtask

    task automatic test_move_right();
        bit ok;
        int nx;
        int n;
        clear_logs();
        press(1);
        tick($urandom_range(5, 40));
        checks++; if (obs_q.size() != 0 || busy_seen != 0) begin errors++; $display("[TB] FAIL right_pre_vblank: got %0d writes %0d busy want 0 0", obs_q.size(), busy_seen); end
        pulse_vblank();
        wait_idle(1000, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL right_timeout: busy never fell"); end
        nx = moved(model_x, 1'b0);
        push_rect(model_x, 3'b000);
        push_rect(nx, 3'b111);
        model_x = nx;
        checks++; if (obs_q.size() != 256) begin errors++; $display("[TB] FAIL right_write_count: got %0d want 256", obs_q.size()); end
        n = seq_mismatch(0);
        checks++; if (n != 0) begin errors++; $display("[TB] FAIL right_sequence: %0d bad, first at %0d got %h want %h", n, bad_idx, bad_got, bad_exp); end
        n = gap_count(0);
        checks++; if (n != 0) begin errors++; $display("[TB] FAIL right_gapless: got %0d gaps want 0", n); end
        checks++; if (sprite_x !== 8'(model_x)) begin errors++; $display("[TB] FAIL right_sprite_x: got %0d want %0d", sprite_x, model_x); end
    endtask

    task automatic test_init_mid_draw();
        bit ok;
        int target;
        int idx0;
        int t0;
        int found;
        int n;
        clear_logs();
        press(1);
        pulse_vblank();
        target = 128 + $urandom_range(5, 60);
        for (int i = 0; i < 400 && obs_q.size() < target; i++) @(negedge clk);
        checks++; if (obs_q.size() < target) begin errors++; $display("[TB] FAIL initdraw_reach: got %0d writes want %0d", obs_q.size(), target); end
        tick(1);
        idx0 = obs_q.size();
        t0 = cycle;
        init = 1'b0;
        tick(10);
        init = 1'b1;
        found = -1;
        for (int i = idx0; i < obs_q.size(); i++)
            if (found < 0 && obs_q[i][17:3] == 15'd0) found = i;
        checks++; if (found < 0 || stamp_q[found] - t0 > 5) begin errors++; $display("[TB] FAIL initdraw_restart: idx %0d, latency %0d want <=5", found, (found < 0) ? -1 : stamp_q[found] - t0); end
        checks++; if (sprite_x !== 8'(HOME)) begin errors++; $display("[TB] FAIL initdraw_sprite_x: got %0d want %0d", sprite_x, HOME); end
        wait_idle(25000, ok);
        model_x = HOME;
        push_clear();
        push_rect(HOME, 3'b111);
        if (found >= 0) begin
            n = seq_mismatch(found);
            checks++; if (n != 0 || obs_q.size() - found != exp_q.size()) begin errors++; $display("[TB] FAIL initdraw_sequence: %0d bad, count %0d, first at %0d got %h want %h", n, obs_q.size() - found, bad_idx, bad_got, bad_exp); end
        end
        checks++; if (!ok) begin errors++; $display("[TB] FAIL initdraw_timeout: busy never fell"); end
    endtask

    task automatic test_press_during_erase();
        bit ok;
        int mid;
        int n;
        clear_logs();
        press(1);
        pulse_vblank();
        for (int i = 0; i < 50 && obs_q.size() < 10; i++) @(negedge clk);
        checks++; if (obs_q.size() < 10) begin errors++; $display("[TB] FAIL erase_reach: got %0d writes want >=10", obs_q.size()); end
        tick(1);
        press(1);
        wait_idle(1000, ok);
        mid = moved(model_x, 1'b0);
        push_rect(model_x, 3'b000);
        push_rect(mid, 3'b111);
        model_x = mid;
        n = seq_mismatch(0);
        checks++; if (n != 0 || obs_q.size() != 256) begin errors++; $display("[TB] FAIL erase_first_move: %0d bad, count %0d want 256", n, obs_q.size()); end
        checks++; if (sprite_x !== 8'(model_x)) begin errors++; $display("[TB] FAIL erase_first_x: got %0d want %0d", sprite_x, model_x); end
        tick($urandom_range(5, 30));
        checks++; if (obs_q.size() != 256) begin errors++; $display("[TB] FAIL erase_waits_vblank: got %0d writes want 256", obs_q.size()); end
        clear_logs();
        pulse_vblank();
        wait_idle(1000, ok);
        mid = moved(model_x, 1'b0);
        push_rect(model_x, 3'b000);
        push_rect(mid, 3'b111);
        model_x = mid;
        n = seq_mismatch(0);
        checks++; if (n != 0 || obs_q.size() != 256) begin errors++; $display("[TB] FAIL erase_second_move: %0d bad, count %0d want 256", n, obs_q.size()); end
        checks++; if (sprite_x !== 8'(model_x)) begin errors++; $display("[TB] FAIL erase_second_x: got %0d want %0d", sprite_x, model_x); end
    endtask

    task automatic test_left_saturate();
        bit ok;
        int nx;
        int n;
        for (int k = 0; k < 40 && model_x > 0; k++) begin
            clear_logs();
            press(0);
            tick($urandom_range(0, 10));
            pulse_vblank();
            wait_idle(1000, ok);
            nx = moved(model_x, 1'b1);
            push_rect(model_x, 3'b000);
            push_rect(nx, 3'b111);
            model_x = nx;
            n = seq_mismatch(0);
            checks++; if (n != 0 || obs_q.size() != 256) begin errors++; $display("[TB] FAIL left_step%0d: %0d bad, count %0d, first at %0d got %h want %h", k, n, obs_q.size(), bad_idx, bad_got, bad_exp); end
            checks++; if (sprite_x !== 8'(model_x)) begin errors++; $display("[TB] FAIL left_x%0d: got %0d want %0d", k, sprite_x, model_x); end
        end
        clear_logs();
        press(0);
        pulse_vblank();
        tick(10);
        checks++; if (obs_q.size() != 0) begin errors++; $display("[TB] FAIL left_sat_writes: got %0d want 0", obs_q.size()); end
        checks++; if (busy_seen != 0) begin errors++; $display("[TB] FAIL left_sat_busy: got %0d busy cycles want 0", busy_seen); end
        checks++; if (sprite_x !== 8'd0) begin errors++; $display("[TB] FAIL left_sat_x: got %0d want 0", sprite_x); end
    endtask

    task automatic test_rst_mid_clear();
        bit ok;
        int n;
        press(2);
        tick($urandom_range(20, 300));
        @(negedge clk);
        checks++; if (fb_we !== 1'b1) begin errors++; $display("[TB] FAIL rstclr_active: got we=%b want 1", fb_we); end
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        checks++; if (fb_we !== 1'b0) begin errors++; $display("[TB] FAIL rstclr_async_we: got %b want 0", fb_we); end
        checks++; if (fb_addr !== 15'd0) begin errors++; $display("[TB] FAIL rstclr_async_addr: got %0d want 0", fb_addr); end
        checks++; if (sprite_x !== 8'(HOME)) begin errors++; $display("[TB] FAIL rstclr_sprite_x: got %0d want %0d", sprite_x, HOME); end
        tick(3);
        clear_logs();
        rst = 1'b1;
        wait_idle(25000, ok);
        model_x = HOME;
        push_clear();
        push_rect(HOME, 3'b111);
        n = seq_mismatch(0);
        checks++; if (n != 0 || obs_q.size() != exp_q.size() || !ok) begin errors++; $display("[TB] FAIL rstclr_restart: %0d bad, count %0d, idle %0b", n, obs_q.size(), ok); end
    endtask

    task automatic test_random_moves();
        bit ok;
        int op;
        int nx;
        int n;
        for (int k = 0; k < 12; k++) begin
            clear_logs();
            op = $urandom_range(0, 2);
            if (op == 2) begin
                press(0);
                press(1);
            end else begin
                press(op);
            end
            tick($urandom_range(0, 15));
            pulse_vblank();
            wait_idle(1000, ok);
            if (op != 2) begin
                nx = moved(model_x, op == 0);
                if (nx != model_x) begin
                    push_rect(model_x, 3'b000);
                    push_rect(nx, 3'b111);
                    model_x = nx;
                end
            end
            n = seq_mismatch(0);
            checks++; if (n != 0 || obs_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL rand%0d_op%0d: %0d bad, count %0d want %0d", k, op, n, obs_q.size(), exp_q.size()); end
            checks++; if (sprite_x !== 8'(model_x)) begin errors++; $display("[TB] FAIL rand%0d_x: got %0d want %0d", k, sprite_x, model_x); end
        end
    endtask

    initial begin
        $display("[TB] starting vga_sprite_draw_ctrl bench");
        test_reset();
        test_both_buttons();
        test_move_right();
        test_init_mid_draw();
        test_press_during_erase();
        test_left_saturate();
        test_rst_mid_clear();
        test_random_moves();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_sprite_draw_ctrl.md
Name: vga_sprite_draw_ctrl

Overview:
- Sequencer owning the write port of the 160x120, 3-bit (1b R/G/B) framebuffer that the VGA scan-out reads.
- On reset or the init button, clears the frame, then draws a rectangular sprite centred horizontally.
- On a left or right button press, moves the sprite by STEP pixels.
- Erases the old sprite and redraws it at the new position, starting only on a vertical-blank pulse so scan-out never shows a half-drawn sprite.

Parameters:
- H_RES, 160, framebuffer width in pixels
- V_RES, 120, framebuffer height in pixels
- AW, 15, framebuffer address width (H_RES*V_RES = 19200 < 2^15)
- DW, 3, pixel width {R,G,B}
- SPR_W, 16, sprite width
- SPR_H, 8, sprite height
- SPR_Y, 100, sprite top row (fixed)
- STEP, 4, pixels moved per press
- BG_COLOR, 3'b000, background / erase colour
- SPR_COLOR, 3'b111, sprite colour

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset (0 = reset)
- init  in  1  clear/restart button, active-low, asynchronous to clk
- bntl  in  1  move-left button, active-low, asynchronous
- bntr  in  1  move-right button, active-low, asynchronous
- vblank_start  in  1  one-cycle pulse from VGA timing at start of vertical blanking
- fb_we  out  1  framebuffer write enable
- fb_addr  out  AW  write address, row*H_RES+col
- fb_data  out  DW  write pixel
- busy  out  1  high in any state other than IDLE
- sprite_x  out  8  current sprite left column

Behaviour:
- Reset values (rst=0): fb_we=0, fb_addr=0, fb_data=BG_COLOR, sprite_x=(H_RES-SPR_W)/2=72, pending flags cleared, state=CLEAR_ARM.
- On rst release, state goes to CLEAR on the first clk edge.
- Button inputs: each passes 2-FF synchronizer, then falling-edge detect, giving a 1-cycle press pulse. Held buttons produce no repeats.
- A left/right press pulse sets pend_l/pend_r in any state. Repeat presses while pending are absorbed (one move).
- init press in any state: abort the current operation, sprite_x=72, clear pend_l/pend_r, and go to CLEAR next cycle. init has priority over all other events.
- States:
  - CLEAR_ARM: load counter=0 → CLEAR.
  - CLEAR: one write per cycle, addr 0..H_RES*V_RES-1 (19200 writes), data BG_COLOR; after the last write → DRAW (no vblank wait).
  - IDLE: fb_we=0. If vblank_start=1 and (pend_l or pend_r): compute new_x.
    - If pend_l and pend_r are both set: clear both, no motion, stay IDLE.
    - Left: new_x = (x>=STEP) ? x-STEP : 0. Right: new_x = min(x+STEP, H_RES-SPR_W).
    - new_x==x (saturated): clear the flag, no writes, stay IDLE.
    - Else: latch old_x=x, clear the flag → ERASE.
    - vblank_start outside IDLE is ignored; pending moves wait for the next pulse.
  - ERASE: SPR_W*SPR_H (128) writes of BG_COLOR over the rectangle at old_x, rows SPR_Y..SPR_Y+SPR_H-1. Order is row-major, column fastest. Then sprite_x=new_x → DRAW.
  - DRAW: 128 writes of SPR_COLOR at sprite_x, same order → IDLE.
- Address generation: row base held in a register and incremented by H_RES per row (no multiplier); fb_addr = row_base + col.
- fb_we/fb_addr/fb_data are registered. The first write is valid the cycle after state entry; writes are back-to-back with no gaps.
- busy = (state != IDLE), registered with the state.
- sprite_x range is always 0..H_RES-SPR_W (144).
- rst assertion mid-operation: outputs go to reset values immediately and asynchronously. Partial framebuffer content is redone by the following CLEAR.

Decomposition:
- Package vga_fb_pkg:
  - H_RES, V_RES, AW, DW
  - BG_COLOR, SPR_COLOR
  - state enum {CLEAR_ARM, CLEAR, IDLE, ERASE, DRAW}
- Sub-module btn_sync_edge (2-FF sync + falling-edge pulse, async active-low reset to "released" = 1), instanced three times for init, bntl and bntr.

Test Plan:
- Reset release, buttons high → exactly 19200 writes of 000 at addr 0..19199, then 128 writes of 111. First draw addr 16072 (100*160+72), last 17207. busy falls afterward; sprite_x=72.
- bntr press, then vblank_start → 128 writes of 000 starting at addr 16072, then 128 writes of 111 starting at 16076. sprite_x=76. No writes before the vblank pulse.
- 18 bntl presses, each followed by vblank → sprite_x reaches 0. A further bntl press plus vblank produces zero writes, busy stays 0, sprite_x=0.
- bntl and bntr both pressed before one vblank_start → no writes, both flags cleared, sprite_x unchanged at 72.
- bntr pressed during ERASE → current move completes. The next vblank_start triggers a second move, giving sprite_x=80.
- init pressed mid-DRAW → within 2 cycles of the synchronized edge, CLEAR restarts at addr 0 and sprite_x=72. rst=0 mid-CLEAR → fb_we=0 immediately (asynchronous), and CLEAR restarts after release.
